// File: rtl/kamus_pkg.sv
// Shared types for the kamus core.
// Holds the decoded operation set, register names, and the load/store unit's error and state encodings.
package kamus_pkg;

   typedef enum logic [4:0] {
      ADD, SUB, SLL, SRL, SRA, SLT, SLTU, LUI, JAL, BEQ,
      LB, LH, LW, LBU, LHU, SB, SH, SW
   } operation_e;

   typedef enum logic [4:0] {
      X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,  X8,  X9,  X10, X11, X12, X13, X14, X15,
      X16, X17, X18, X19, X20, X21, X22, X23, X24, X25, X26, X27, X28, X29, X30, X31
   } register_e;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_MISALIGNED = 2'd1,
      ERR_BUS        = 2'd2,
      ERR_ILLEGAL    = 2'd3
   } lsu_err_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   function automatic logic is_mem_op(operation_e op);
      return (op == LB) || (op == LH) || (op == LW) || (op == LBU) ||
             (op == LHU) || (op == SB) || (op == SH) || (op == SW);
   endfunction

   function automatic logic is_store_op(operation_e op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store-data replication,
// the misalignment flag, and load-data extraction with sign/zero extension.
module kamus_lsu_align
   import kamus_pkg::*;
(
   input  operation_e  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         2'd3:    byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      be_o         = 4'b0000;
      wdata_o      = 32'd0;
      misaligned_o = 1'b0;
      rdata_o      = 32'd0;
      case (op_i)
         LB, LBU, SB: be_o = 4'b0001 << addr_lo_i;
         LH, LHU, SH: begin
            be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
            misaligned_o = addr_lo_i[0];
         end
         LW, SW: begin
            be_o         = 4'b1111;
            misaligned_o = |addr_lo_i;
         end
         default: ;
      endcase
      // Store data goes out on every lane so the memory picks it up whatever be selects.
      case (op_i)
         LB:      rdata_o = {{24{byte_sel[7]}}, byte_sel};
         LBU:     rdata_o = {24'd0, byte_sel};
         LH:      rdata_o = {{16{half_sel[15]}}, half_sel};
         LHU:     rdata_o = {16'd0, half_sel};
         LW:      rdata_o = rdata_i;
         SB:      wdata_o = {4{wdata_i[7:0]}};
         SH:      wdata_o = {2{wdata_i[15:0]}};
         SW:      wdata_o = wdata_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/kamus_lsu.sv
// Load/store unit: one transaction at a time over the L1 data-memory req/gnt/rvalid port,
// returning a formatted, tagged load result or an error cause to writeback.
module kamus_lsu
   import kamus_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  operation_e  op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  register_e   rd_addr_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_err_i,
   output logic        rsp_valid_o,
   output logic        rsp_we_o,
   output register_e   rsp_rd_addr_o,
   output logic [31:0] rsp_rdata_o,
   output lsu_err_e    rsp_err_o,
   output logic        busy_o
);

   lsu_state_e  state_q;
   operation_e  op_q;
   logic [1:0]  addr_lo_q;
   register_e   rd_q;
   logic        ready_q;
   logic        busy_q;
   logic        dmem_req_q;
   logic        dmem_we_q;
   logic [3:0]  dmem_be_q;
   logic [31:0] dmem_addr_q;
   logic [31:0] dmem_wdata_q;
   logic        rsp_valid_q;
   logic        rsp_we_q;
   register_e   rsp_rd_q;
   logic [31:0] rsp_rdata_q;
   lsu_err_e    rsp_err_q;

   logic        idle;
   operation_e  al_op;
   logic [1:0]  al_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_mis;

   // The aligner sees the incoming op while idle and the latched op afterwards.
   assign idle  = (state_q == IDLE);
   assign al_op = idle ? op_i : op_q;
   assign al_lo = idle ? addr_i[1:0] : addr_lo_q;

   kamus_lsu_align u_align (
      .op_i         (al_op),
      .addr_lo_i    (al_lo),
      .wdata_i      (wdata_i),
      .rdata_i      (dmem_rdata_i),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .misaligned_o (al_mis),
      .rdata_o      (al_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         op_q         <= ADD;
         addr_lo_q    <= 2'd0;
         rd_q         <= X0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_be_q    <= 4'd0;
         dmem_addr_q  <= 32'd0;
         dmem_wdata_q <= 32'd0;
         rsp_valid_q  <= 1'b0;
         rsp_we_q     <= 1'b0;
         rsp_rd_q     <= X0;
         rsp_rdata_q  <= 32'd0;
         rsp_err_q    <= ERR_NONE;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i && ready_q) begin
                  op_q      <= op_i;
                  addr_lo_q <= addr_i[1:0];
                  rd_q      <= rd_addr_i;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  if (!is_mem_op(op_i) || al_mis) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_we_q    <= 1'b0;
                     rsp_rd_q    <= rd_addr_i;
                     rsp_rdata_q <= 32'd0;
                     rsp_err_q   <= is_mem_op(op_i) ? ERR_MISALIGNED : ERR_ILLEGAL;
                  end else begin
                     state_q      <= REQ;
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= is_store_op(op_i);
                     dmem_be_q    <= al_be;
                     dmem_addr_q  <= {addr_i[31:2], 2'b00};
                     dmem_wdata_q <= al_wdata;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            REQ: begin
               if (dmem_gnt_i) begin
                  state_q    <= WAIT;
                  dmem_req_q <= 1'b0;
               end
            end
            WAIT: begin
               if (dmem_rvalid_i) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rd_q    <= rd_q;
                  if (dmem_err_i) begin
                     rsp_err_q   <= ERR_BUS;
                     rsp_we_q    <= 1'b0;
                     rsp_rdata_q <= 32'd0;
                  end else begin
                     rsp_err_q   <= ERR_NONE;
                     rsp_we_q    <= !dmem_we_q;
                     rsp_rdata_q <= dmem_we_q ? 32'd0 : al_rdata;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o   = ready_q;
   assign busy_o        = busy_q;
   assign dmem_req_o    = dmem_req_q;
   assign dmem_we_o     = dmem_we_q;
   assign dmem_be_o     = dmem_be_q;
   assign dmem_addr_o   = dmem_addr_q;
   assign dmem_wdata_o  = dmem_wdata_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_we_o      = rsp_we_q;
   assign rsp_rd_addr_o = rsp_rd_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign rsp_err_o     = rsp_err_q;

endmodule

// File: doc/kamus_lsu.md
# kamus_lsu

Load/store unit for the kamus core, directly downstream of the decode/execute stage. It accepts one decoded memory operation at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) with an ALU-computed address, and drives the L1 data-memory request/grant/response port. It returns an aligned, sign- or zero-extended load result, tagged with its destination register, to the writeback mux (MEM_RESULT path). Misaligned accesses, bus errors and non-memory operations are reported as errors without a register write.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  execute stage presents an operation
- req_ready_o  out  1  LSU can accept; high only in IDLE
- op_i  in  operation_e  decoded operation
- addr_i  in  32  effective byte address
- wdata_i  in  32  store data (rs2)
- rd_addr_i  in  register_e  load destination
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = store
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response valid, for loads and stores
- dmem_rdata_i  in  32  load word
- dmem_err_i  in  1  bus error; qualified by rvalid
- rsp_valid_o  out  1  one-cycle result pulse
- rsp_we_o  out  1  regfile write enable
- rsp_rd_addr_o  out  register_e  destination
- rsp_rdata_o  out  32  formatted load data
- rsp_err_o  out  lsu_err_e  error cause
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid_i, latch op, addr, wdata and rd.
  - Memory operation, aligned: go to REQ.
  - Misaligned or non-memory operation: go to RESP with the error code; no memory access.
- REQ: dmem_req_o=1. Address, we, be and wdata come from registers and stay stable until grant. On dmem_gnt_i go to WAIT.
- WAIT: on dmem_rvalid_i, register the formatted data and the error, then go to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle, then go to IDLE.
- Alignment rules:
  - Halfword is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Byte accesses are never misaligned.
- Byte enables:
  - SB: 4'b0001<<addr[1:0]; wdata = byte replicated into all 4 lanes.
  - SH: 4'b0011<<{addr[1],1'b0}; wdata = halfword replicated into both lanes.
  - SW: 4'b1111.
  - Loads: same byte-enable rules, dmem_we_o=0.
- Load formatting: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rsp_we_o=1 only for a load with rsp_err_o=NONE. Stores always give rsp_we_o=0 and rsp_rdata_o=0.
- Error codes: NONE=0, MISALIGNED=1, BUS=2, ILLEGAL=3. On BUS, rsp_rdata_o=0.
- Only one outstanding transaction. req_valid_i is ignored unless in IDLE.

## Timing
- Reset values: every output 0, rsp_err_o=NONE, state IDLE. Reset applies asynchronously, so dmem_req_o drops immediately on rst_i.
- Accept in cycle T → dmem_req_o from T+1.
- With a zero-wait memory (gnt at T+1, rvalid at T+2), rsp_valid_o is high at T+3. This 3-cycle latency is the minimum.
- Each cycle of gnt-low adds one cycle; each cycle of rvalid delay adds one cycle.
- Misaligned or illegal operation: rsp_valid_o at T+1; dmem_req_o never asserts.
- rvalid while not in WAIT: ignored. gnt while not in REQ: ignored.
- Reset in REQ or WAIT: the transaction is abandoned; a later rvalid from it is ignored.
- Next acceptance is possible in the cycle after RESP, i.e. T+4 back-to-back.

## Structure
- Add to kamus_pkg:
  - typedef lsu_err_e (2-bit).
  - typedef lsu_state_e.
  - Function is_mem_op(operation_e).
- Sub-module kamus_lsu_align: combinational. From op and addr[1:0] it computes byte enables, replicated wdata, the misalignment flag, and the formatted load data.
- kamus_lsu holds the FSM and the registers.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with immediate gnt → dmem_addr 0x100, be 1111; rsp_valid at T+3, rdata 0xDEADBEEF, we=1, err=NONE.
- LB at 0x103 with rdata 0x80123456 → rsp_rdata 0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF8012.
- SH at 0x102, wdata 0x1234ABCD → dmem_addr 0x100, be 1100, wdata 0xABCDABCD, we=1; rsp we=0.
- LW at 0x101 → no dmem_req; rsp_valid at T+1 with err=MISALIGNED, we=0. An op_i of ADD → err=ILLEGAL at T+1.
- gnt held low 3 cycles, then rvalid with dmem_err_i=1 → request signals stable throughout; req_ready_o=0 and a second req_valid_i is ignored; response err=BUS, we=0, rdata 0.
- rst_i pulsed while in WAIT, then a stale rvalid arrives → all outputs 0 asynchronously; no rsp_valid; the next LW completes normally.
